mac_accum: RTL and testbench
============================

# mac_accum

Signed accumulate stage directly downstream of the signed multiplier in the convolution datapath. It consumes one WIDTH_P-bit product per accepted beat and sums TAPS consecutive products, one kernel window per group. Each completed sum is arithmetically right-shifted by SHIFT and saturated to OUT_W bits. The result is held in a registered output with valid/ready backpressure for the writeback stage.

## Interface
- WIDTH_P, 16: signed product width; equals WIDTH_A+WIDTH_B of the multiplier (8+8).
- TAPS, 9: products summed per result; at least 2.
- OUT_W, 8: signed result width.
- SHIFT, 4: arithmetic right shift applied to the final sum; 0 ≤ SHIFT < ACC_W.
- ACC_W (localparam) = WIDTH_P + $clog2(TAPS); internal accumulator width; never overflows.
- Ports, clock and reset first:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- clear  input  1  synchronous flush; takes priority over all other inputs.
- in_prod  input  WIDTH_P  signed product from the multiplier.
- in_valid  input  1  in_prod is valid.
- in_ready  output  1  stage can accept; combinational, equals ~out_valid | out_ready.
- out_data  output  OUT_W  signed saturated result, registered.
- out_sat  output  1  out_data was clipped; registered with out_data.
- out_valid  output  1  out_data/out_sat hold a result, registered.
- out_ready  input  1  downstream accepts the result.

## Operation
- State: cnt (0..TAPS-1), acc (ACC_W, signed), and the output register (out_data, out_sat, out_valid).
- Accept: in_valid & in_ready.
- Reset (rst high, asynchronous): cnt=0, acc=0, out_data=0, out_sat=0, out_valid=0. in_ready reads 1 while rst is high. Any partial group is discarded.
- clear high at an edge: cnt←0, acc←0, out_valid←0. A pending result is dropped, and any in_prod presented that cycle is not accumulated.
- On accept, sum = (cnt==0 ? 0 : acc) + sext(in_prod).
  - cnt < TAPS-1: acc←sum, cnt←cnt+1.
  - cnt == TAPS-1: cnt←0, acc←0, and the output register loads from sum, out_valid←1.
- Output calculation:
  - s = sum >>> SHIFT, arithmetic, rounding toward −∞.
  - If s > 2^(OUT_W-1)−1: out_data = max, out_sat = 1.
  - If s < −2^(OUT_W-1): out_data = min, out_sat = 1.
  - Otherwise out_data = s[OUT_W-1:0], out_sat = 0.
- Output handshake:
  - out_valid & out_ready with no completion in the same cycle: out_valid←0. out_data and out_sat keep their values.
  - out_valid & out_ready with a completion in the same cycle: the new result replaces the old one and out_valid stays 1.
  - out_valid & ~out_ready: in_ready=0, and the output register and acc do not change.
- Group boundaries follow accepted beats only. Idle cycles (in_valid=0) do not advance cnt.

## Timing
- Latency: the TAPS-th product is accepted at edge k; out_valid=1 and out_data are valid immediately after edge k.
- Throughput: one product per cycle, sustained, while out_ready=1. No bubble between groups.
- in_ready has a combinational path from out_ready. No other combinational path runs from input to output.
- out_data is stable while out_valid=1 and out_ready=0.

## Test plan
- Basic group: params as default; nine accepted beats of in_prod=16, out_ready=1 → one cycle after the 9th beat, out_valid=1, out_data=9, out_sat=0.
- Positive saturation: nine beats of 32767 (sum 294903, shifted 18431) → out_data=127, out_sat=1. Negative floor and rounding: nine beats of −100 (sum −900) → out_data=−57, out_sat=0.
- Back-to-back groups: 18 consecutive beats of 16, out_ready=1 → two results of 9 on consecutive group boundaries; in_ready never drops to 0.
- Backpressure:
  - Complete a group with out_ready=0 → in_ready=0, and out_data=9 holds for 5 cycles while in_valid=1 with no beat accepted.
  - Raise out_ready → the pending beat is accepted that same cycle, and out_valid drops the next cycle.
- clear mid-group: accept 4 beats of 1000, pulse clear, then 9 beats of 16 → result 9; the 1000s do not contribute. clear while out_valid=1 → out_valid=0 at the next edge.
- Async reset mid-group: assert rst between edges after 5 beats → all outputs reach reset values without waiting for a clock edge. After release, 9 beats of 16 → out_data=9.

Source files
------------

// File: rtl/mac_accum.sv
// rtl/mac_accum.sv - signed TAPS-product accumulator with shift, saturation and registered output
module mac_accum #(
    parameter int WIDTH_P = 16,
    parameter int TAPS    = 9,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic signed [WIDTH_P-1:0] in_prod,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [OUT_W-1:0]   out_data,
    output logic                      out_sat,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int ACC_W = WIDTH_P + $clog2(TAPS);
    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [OUT_W-1:0] sat_data;
    logic                    sat_flag;
    logic                    accept;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign prod_ext = {{(ACC_W - WIDTH_P){in_prod[WIDTH_P-1]}}, in_prod};
    // The first beat of a group starts from zero so acc never needs a separate restart.
    assign sum      = ((cnt == '0) ? '0 : acc) + prod_ext;
    assign shifted  = sum >>> SHIFT;

    always_comb begin
        sat_flag = 1'b0;
        sat_data = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_flag = 1'b1;
            sat_data = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_flag = 1'b1;
            sat_data = SAT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A completion in the same cycle as a drain overrides the drop above.
            if (accept) begin
                if (cnt == LAST) begin
                    cnt       <= '0;
                    acc       <= '0;
                    out_data  <= sat_data;
                    out_sat   <= sat_flag;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// tb/tb_mac_accum.sv - randomized and directed checks of mac_accum against a group-sum model
module tb_mac_accum;

    localparam int WIDTH_P = 16;
    localparam int TAPS    = 9;
    localparam int OUT_W   = 8;
    localparam int SHIFT   = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      clear = 1'b0;
    logic signed [WIDTH_P-1:0] in_prod = '0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic signed [OUT_W-1:0]   out_data;
    logic                      out_sat;
    logic                      out_valid;
    logic                      out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    longint gsum = 0;
    int     gcnt = 0;
    bit     ev = 0;
    longint ed = 0;
    bit     es = 0;

    mac_accum #(.WIDTH_P(WIDTH_P), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_prod(in_prod), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, longint'(out_valid), longint'(ev));
        check({tag, ".out_data"}, longint'(out_data), ed);
        check({tag, ".out_sat"}, longint'(out_sat), longint'(es));
    endtask

    // Floor division by 2**SHIFT, then clip to the signed OUT_W range.
    task automatic finish_group();
        longint div = longint'(1) << SHIFT;
        longint q;
        longint hi = (longint'(1) << (OUT_W - 1)) - 1;
        longint lo = -(longint'(1) << (OUT_W - 1));
        q = (gsum >= 0) ? gsum / div : -((-gsum + div - 1) / div);
        es = 0;
        if (q > hi) begin ed = hi; es = 1; end
        else if (q < lo) begin ed = lo; es = 1; end
        else ed = q;
        ev = 1;
        gsum = 0;
        gcnt = 0;
    endtask

    task automatic step(input string tag, input bit v, input logic signed [WIDTH_P-1:0] p,
                        input bit rdy, input bit clr);
        bit acc_ok;
        in_valid  = v;
        in_prod   = p;
        out_ready = rdy;
        clear     = clr;
        #1;
        check({tag, ".in_ready"}, longint'(in_ready), longint'(!ev || rdy));
        @(posedge clk);
        if (clr) begin
            gsum = 0; gcnt = 0; ev = 0;
        end else begin
            acc_ok = v && (!ev || rdy);
            if (ev && rdy) ev = 0;
            if (acc_ok) begin
                gsum += longint'(p);
                gcnt++;
                if (gcnt == TAPS) finish_group();
            end
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic beats(input string tag, input int n, input logic signed [WIDTH_P-1:0] p,
                         input bit rdy);
        for (int i = 0; i < n; i++) step(tag, 1'b1, p, rdy, 1'b0);
    endtask

    // Asserted between edges: outputs must clear before any clock edge arrives.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #2;
        gsum = 0; gcnt = 0; ev = 0; ed = 0; es = 0;
        check_outputs(tag);
        check({tag, ".in_ready"}, longint'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2;
        check_outputs("reset");
        check("reset.in_ready", longint'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        beats("basic", TAPS, 16'sd16, 1'b1);
        check("basic.value", longint'(out_data), 9);
        beats("possat", TAPS, 16'sd32767, 1'b1);
        check("possat.value", longint'(out_data), 127);
        check("possat.sat", longint'(out_sat), 1);
        beats("negfloor", TAPS, -16'sd100, 1'b1);
        check("negfloor.value", longint'(out_data), -57);
        check("negfloor.sat", longint'(out_sat), 0);

        for (int i = 0; i < 2 * TAPS; i++) begin
            step("b2b", 1'b1, 16'sd16, 1'b1, 1'b0);
            check("b2b.ready_high", longint'(in_ready), 1);
        end

        step("bp_drain", 1'b0, 16'sd0, 1'b1, 1'b0);
        beats("bp_fill", TAPS, 16'sd16, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("bp_hold", 1'b1, 16'sd16, 1'b0, 1'b0);
            check("bp_hold.value", longint'(out_data), 9);
        end
        step("bp_release", 1'b1, 16'sd16, 1'b1, 1'b0);
        check("bp_release.valid_drop", longint'(out_valid), 0);
        beats("bp_rest", TAPS - 1, 16'sd16, 1'b1);

        beats("clr_part", 4, 16'sd1000, 1'b1);
        step("clr_pulse", 1'b1, 16'sd1000, 1'b1, 1'b1);
        beats("clr_group", TAPS, 16'sd16, 1'b1);
        check("clr_group.value", longint'(out_data), 9);
        step("clr_v_drain", 1'b0, 16'sd0, 1'b1, 1'b0);
        beats("clr_v_fill", TAPS, 16'sd16, 1'b0);
        step("clr_v", 1'b0, 16'sd0, 1'b0, 1'b1);
        check("clr_v.valid", longint'(out_valid), 0);

        beats("ar_fill", TAPS, 16'sd32767, 1'b0);
        async_reset("ar_held");
        beats("ar_part", 5, 16'sd1000, 1'b1);
        async_reset("ar_part");
        beats("ar_after", TAPS, 16'sd16, 1'b1);
        check("ar_after.value", longint'(out_data), 9);

        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), WIDTH_P'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 200; i++) begin
            step("rand_small", 1'b1, WIDTH_P'($signed($urandom_range(0, 511)) - 256),
                 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
